sram_like_arbiter: RTL and testbench
====================================

// Module: sram_like_arbiter
// PURPOSE
//  Merges the CPU's inst and data SRAM-like master ports onto one SRAM-like slave port (single-port
//  memory or bus bridge). Sits between mycpu_top and the memory side. Grants one request per cycle,
//  tracks outstanding transactions in order and routes each data_ok/rdata back to its owner.
// PARAMETERS
//  OUTSTANDING_DEPTH  4   max accepted-but-unanswered requests (power of 2, >=2)
// PORTS
//  clk                         in   1       clock; everything rising-edge
//  reset                       in   1       asynchronous, active-high
//  inst_sram_req               in   1       inst master request
//  inst_sram_{wr,size,addr,wstrb,wdata} in 1/2/32/4/32  inst request payload
//  inst_sram_addr_ok           out  1       inst request accepted
//  inst_sram_data_ok           out  1       inst response valid
//  inst_sram_rdata             out  32      inst read data
//  data_sram_req               in   1       data master request
//  data_sram_{wr,size,addr,wstrb,wdata} in 1/2/32/4/32  data request payload
//  data_sram_addr_ok           out  1       data request accepted
//  data_sram_data_ok           out  1       data response valid
//  data_sram_rdata             out  32      data read data
//  mem_sram_req                out  1       merged request
//  mem_sram_{wr,size,addr,wstrb,wdata} out 1/2/32/4/32  payload of granted master
//  mem_sram_addr_ok            in   1       slave accepted request
//  mem_sram_data_ok            in   1       slave response valid
//  mem_sram_rdata              in   32      slave read data
// BEHAVIOUR
//  - Reset: ID FIFO empty, lock cleared, rr pointer = data; while reset high all req/addr_ok/data_ok outputs 0.
//  - Grant (comb.): if lock set, grant = locked owner; else data wins over inst (see CONFIGURATION).
//  - mem_sram_req = granted master's req & ~fifo_full; payload muxed from granted master, zero latency.
//  - <owner>_addr_ok = mem_sram_addr_ok & mem_sram_req & grant==owner; non-granted addr_ok = 0.
//  - Lock: mem_sram_req & ~mem_sram_addr_ok -> lock<=1, owner held until accept; payload must not
//    switch masters while slave stalls. Accept clears lock same edge.
//  - Accept (req & addr_ok): push owner ID (0=inst,1=data) into FIFO; on FIFO full mem_sram_req=0,
//    no addr_ok to either master, lock unaffected.
//  - mem_sram_data_ok: pop head; assert head's data_ok same cycle (comb., 0 latency); rdata broadcast.
//  - data_ok with FIFO empty: dropped, neither master sees data_ok. Slave returns data_ok >=1 cycle
//    after its addr_ok; same-cycle push of request N and pop of older request legal, count unchanged.
//  - Full + simultaneous pop: push still blocked that cycle (full decided from registered count).
//  - Count wrap: pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits; no overflow/underflow possible.
//  - Reset mid-transaction: outstanding IDs discarded; late slave data_ok after reset is dropped.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: when both req and unlocked, grant the master not granted last
//   (rr pointer updates on each accept). Undefined: fixed priority, data always beats inst.
// STRUCTURE
//  - mycpu.h: `ARB_ID_INST 1'b0, `ARB_ID_DATA 1'b1, `SRAM_CMD_WD 71 ({wr,size,addr,wstrb,wdata}).
//  - Sub-module arb_id_fifo: 1-bit-wide sync FIFO, depth OUTSTANDING_DEPTH, push/pop/full/empty/head.
//  - Top: grant/lock logic, payload mux, response demux.
// TESTING
//  1 inst req addr 0xBFC00000, slave addr_ok same cycle, data_ok 2 cycles later rdata 0x3C08BFAF
//    -> inst_addr_ok 1 cycle, inst_data_ok 1 cycle with rdata, data_data_ok never asserted.
//  2 inst+data req same cycle, addr_ok always 1 -> data granted first, inst next cycle; with
//    ARB_ROUND_ROBIN_EN and prior grant=data, inst granted first.
//  3 data req addr 0x1FAF0000, slave holds addr_ok=0 4 cycles, inst req arrives cycle 1
//    -> mem_sram_addr stays 0x1FAF0000 until accept; inst accepted only afterwards.
//  4 issue 4 inst accepts with no data_ok -> 5th req: mem_sram_req=0; one data_ok -> next cycle accepted.
//  5 accept inst,data,inst; data_ok x3 with rdata 1,2,3 -> inst gets 1, data gets 2, inst gets 3.
//  6 reset pulse with 2 outstanding, then stray data_ok -> both data_ok outputs stay 0, FIFO empty.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the SRAM-like arbiter: master IDs and the packed request command.
package sram_like_arbiter_pkg;

    localparam int SRAM_CMD_WD = 71;

    typedef enum logic {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_cmd_t;

    function automatic sram_cmd_t pack_cmd(
        input logic        wr,
        input logic [1:0]  size,
        input logic [31:0] addr,
        input logic [3:0]  wstrb,
        input logic [31:0] wdata
    );
        sram_cmd_t c;
        c.wr    = wr;
        c.size  = size;
        c.addr  = addr;
        c.wstrb = wstrb;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of owner IDs for accepted-but-unanswered requests.
// Push while full and pop while empty are ignored; full/empty come from the registered count.
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  arb_id_e push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output arb_id_e head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = arb_id_e'(mem_q[rd_ptr_q]);

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the inst and data SRAM-like masters onto one SRAM-like slave port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data always beats inst.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_sram_req,
    output logic        mem_sram_wr,
    output logic [1:0]  mem_sram_size,
    output logic [31:0] mem_sram_addr,
    output logic [3:0]  mem_sram_wstrb,
    output logic [31:0] mem_sram_wdata,
    input  logic        mem_sram_addr_ok,
    input  logic        mem_sram_data_ok,
    input  logic [31:0] mem_sram_rdata
);

    arb_id_e   grant;
    arb_id_e   owner_q, owner_d;
    logic      lock_q, lock_d;
    logic      granted_req;
    logic      accept;
    logic      pop;
    logic      fifo_full, fifo_empty;
    arb_id_e   fifo_head;
    sram_cmd_t inst_cmd, data_cmd, mem_cmd;

`ifdef ARB_ROUND_ROBIN_EN
    arb_id_e   rr_q, rr_d;
`endif

    assign inst_cmd = pack_cmd(inst_sram_wr, inst_sram_size, inst_sram_addr,
                               inst_sram_wstrb, inst_sram_wdata);
    assign data_cmd = pack_cmd(data_sram_wr, data_sram_size, data_sram_addr,
                               data_sram_wstrb, data_sram_wdata);

    // A stalled request keeps its owner so the slave never sees the payload change masters.
    always_comb begin
        grant = ARB_ID_INST;
        if (lock_q) begin
            grant = owner_q;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            if (inst_sram_req && data_sram_req) begin
                grant = (rr_q == ARB_ID_DATA) ? ARB_ID_INST : ARB_ID_DATA;
            end else if (data_sram_req) begin
                grant = ARB_ID_DATA;
            end
`else
            if (data_sram_req) begin
                grant = ARB_ID_DATA;
            end
`endif
        end
    end

    always_comb begin
        granted_req = inst_sram_req;
        mem_cmd     = inst_cmd;
        if (grant == ARB_ID_DATA) begin
            granted_req = data_sram_req;
            mem_cmd     = data_cmd;
        end
    end

    assign mem_sram_req   = granted_req & ~fifo_full & ~reset;
    assign mem_sram_wr    = mem_cmd.wr;
    assign mem_sram_size  = mem_cmd.size;
    assign mem_sram_addr  = mem_cmd.addr;
    assign mem_sram_wstrb = mem_cmd.wstrb;
    assign mem_sram_wdata = mem_cmd.wdata;

    assign accept            = mem_sram_req & mem_sram_addr_ok;
    assign inst_sram_addr_ok = accept & (grant == ARB_ID_INST);
    assign data_sram_addr_ok = accept & (grant == ARB_ID_DATA);

    // Responses return in order; a data_ok with nothing outstanding is dropped.
    assign pop               = mem_sram_data_ok & ~fifo_empty & ~reset;
    assign inst_sram_data_ok = pop & (fifo_head == ARB_ID_INST);
    assign data_sram_data_ok = pop & (fifo_head == ARB_ID_DATA);
    assign inst_sram_rdata   = mem_sram_rdata;
    assign data_sram_rdata   = mem_sram_rdata;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (mem_sram_req) begin
            lock_d  = 1'b1;
            owner_d = grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q  <= 1'b0;
            owner_q <= ARB_ID_DATA;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign rr_d = accept ? grant : rr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= ARB_ID_DATA;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    arb_id_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
    logic [1:0]  inst_sram_size = 2'd2;
    logic [31:0] inst_sram_addr = '0, inst_sram_wdata = '0;
    logic [3:0]  inst_sram_wstrb = '0;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
    logic [1:0]  data_sram_size = 2'd2;
    logic [31:0] data_sram_addr = '0, data_sram_wdata = '0;
    logic [3:0]  data_sram_wstrb = '0;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_sram_req, mem_sram_wr;
    logic [1:0]  mem_sram_size;
    logic [31:0] mem_sram_addr, mem_sram_wdata;
    logic [3:0]  mem_sram_wstrb;
    logic        mem_sram_addr_ok = 1'b0, mem_sram_data_ok = 1'b0;
    logic [31:0] mem_sram_rdata = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_sram_req(mem_sram_req), .mem_sram_wr(mem_sram_wr),
        .mem_sram_size(mem_sram_size), .mem_sram_addr(mem_sram_addr),
        .mem_sram_wstrb(mem_sram_wstrb), .mem_sram_wdata(mem_sram_wdata),
        .mem_sram_addr_ok(mem_sram_addr_ok), .mem_sram_data_ok(mem_sram_data_ok),
        .mem_sram_rdata(mem_sram_rdata)
    );

    typedef struct {
        bit          ireq, dreq, aok, dok;
        logic [31:0] addr, rdata;
        bit          e_req, e_iaok, e_daok, e_idok, e_ddok;
    } vec_t;

    vec_t vecs[11];

    // Reference model state: outstanding owners in order (0=inst, 1=data), lock and last grant.
    bit q[$];
    bit lk, lk_own, last;

    task automatic checkWord(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit ireq, input bit dreq, input bit aok, input bit dok,
                                 input logic [31:0] iaddr, input logic [31:0] daddr,
                                 input logic [31:0] rdata);
        inst_sram_req    = ireq;
        inst_sram_addr   = iaddr;
        inst_sram_wr     = 1'b0;
        data_sram_req    = dreq;
        data_sram_addr   = daddr;
        data_sram_wr     = 1'b1;
        data_sram_wstrb  = 4'h3;
        data_sram_wdata  = 32'hD0D0_0001;
        mem_sram_addr_ok = aok;
        mem_sram_data_ok = dok;
        mem_sram_rdata   = rdata;
    endtask

    task automatic checkOutput(input string tag, input bit e_req, input bit e_iaok,
                               input bit e_daok, input bit e_idok, input bit e_ddok,
                               input logic [31:0] e_addr, input logic [31:0] e_rdata);
        @(negedge clk);
        checkWord({tag, ".mem_req"},  71'(mem_sram_req),      71'(e_req));
        checkWord({tag, ".inst_aok"}, 71'(inst_sram_addr_ok), 71'(e_iaok));
        checkWord({tag, ".data_aok"}, 71'(data_sram_addr_ok), 71'(e_daok));
        checkWord({tag, ".inst_dok"}, 71'(inst_sram_data_ok), 71'(e_idok));
        checkWord({tag, ".data_dok"}, 71'(data_sram_data_ok), 71'(e_ddok));
        if (e_req)  checkWord({tag, ".mem_addr"},   71'(mem_sram_addr),   71'(e_addr));
        if (e_idok) checkWord({tag, ".inst_rdata"}, 71'(inst_sram_rdata), 71'(e_rdata));
        if (e_ddok) checkWord({tag, ".data_rdata"}, 71'(data_sram_rdata), 71'(e_rdata));
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, '0, '0, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic bit modelGrant(input bit ireq, input bit dreq);
        if (lk) return lk_own;
`ifdef ARB_ROUND_ROBIN_EN
        if (ireq && dreq) return ~last;
`else
        if (ireq && dreq) return 1'b1;
`endif
        return dreq;
    endfunction

    initial begin
        bit          g, e_req, e_acc, e_pop, hd;
        logic [70:0] icmd, dcmd;

        // Single-inst read followed by in-order demux of three mixed responses.
        vecs[0]  = '{1, 0, 1, 0, 32'hBFC0_0000, 32'h0,         1, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 32'h0,         32'h3C08_BFAF, 0, 0, 0, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 1, 0, 32'h0000_0100, 32'h0,         1, 1, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 0, 32'h0000_0200, 32'h0,         1, 0, 1, 0, 0};
        vecs[6]  = '{1, 0, 1, 0, 32'h0000_0300, 32'h0,         1, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 32'h0,         32'h1,         0, 0, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 1, 32'h0,         32'h2,         0, 0, 0, 0, 1};
        vecs[9]  = '{0, 0, 0, 1, 32'h0,         32'h3,         0, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 0, 1, 32'h0,         32'h4,         0, 0, 0, 0, 0};

        applyStimulus(1, 1, 1, 1, 32'h1111_0000, 32'h2222_0000, 32'h5);
        #2;
        checkOutput("reset", 0, 0, 0, 0, 0, '0, '0);
        doReset();

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok,
                          vecs[i].addr, vecs[i].addr, vecs[i].rdata);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_iaok, vecs[i].e_daok,
                        vecs[i].e_idok, vecs[i].e_ddok, vecs[i].addr, vecs[i].rdata);
        end

        // Simultaneous requests right after reset.
        doReset();
        applyStimulus(1, 1, 1, 0, 32'hA000_0000, 32'hD000_0000, '0);
`ifdef ARB_ROUND_ROBIN_EN
        checkOutput("both.first", 1, 1, 0, 0, 0, 32'hA000_0000, '0);
        applyStimulus(0, 1, 1, 0, 32'hA000_0000, 32'hD000_0000, '0);
        checkOutput("both.second", 1, 0, 1, 0, 0, 32'hD000_0000, '0);
`else
        checkOutput("both.first", 1, 0, 1, 0, 0, 32'hD000_0000, '0);
        applyStimulus(1, 0, 1, 0, 32'hA000_0000, 32'hD000_0000, '0);
        checkOutput("both.second", 1, 1, 0, 0, 0, 32'hA000_0000, '0);
`endif

        // Reset with two outstanding, then a stray data_ok.
        reset = 1'b1;
        applyStimulus(1, 1, 1, 1, 32'hA000_0000, 32'hD000_0000, 32'h77);
        checkOutput("rst.hold0", 0, 0, 0, 0, 0, '0, '0);
        checkOutput("rst.hold1", 0, 0, 0, 0, 0, '0, '0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, '0, '0, 32'h88);
        checkOutput("rst.stray", 0, 0, 0, 0, 0, '0, '0);
        applyStimulus(1, 0, 1, 0, 32'hA000_0040, '0, '0);
        checkOutput("rst.newreq", 1, 1, 0, 0, 0, 32'hA000_0040, '0);
        applyStimulus(0, 0, 0, 1, '0, '0, 32'h99);
        checkOutput("rst.newresp", 0, 0, 0, 1, 0, '0, 32'h99);

        // Stalled data request must hold the slave payload until accepted.
        doReset();
        applyStimulus(0, 1, 0, 0, 32'h0BAD_0000, 32'h1FAF_0000, '0);
        checkOutput("stall.c0", 1, 0, 0, 0, 0, 32'h1FAF_0000, '0);
        for (int c = 1; c < 4; c++) begin
            applyStimulus(1, 1, 0, 0, 32'h0BAD_0000, 32'h1FAF_0000, '0);
            checkOutput($sformatf("stall.c%0d", c), 1, 0, 0, 0, 0, 32'h1FAF_0000, '0);
        end
        applyStimulus(1, 1, 1, 0, 32'h0BAD_0000, 32'h1FAF_0000, '0);
        checkOutput("stall.accept", 1, 0, 1, 0, 0, 32'h1FAF_0000, '0);
        applyStimulus(1, 0, 1, 0, 32'h0BAD_0000, 32'h1FAF_0000, '0);
        checkOutput("stall.inst", 1, 1, 0, 0, 0, 32'h0BAD_0000, '0);

        // Fill the ID FIFO; pop while full still blocks the push for that cycle.
        doReset();
        for (int c = 0; c < DEPTH; c++) begin
            applyStimulus(1, 0, 1, 0, 32'h100 + 32'(c), '0, '0);
            checkOutput($sformatf("fill%0d", c), 1, 1, 0, 0, 0, 32'h100 + 32'(c), '0);
        end
        applyStimulus(1, 0, 1, 0, 32'h200, '0, '0);
        checkOutput("full.block", 0, 0, 0, 0, 0, '0, '0);
        applyStimulus(1, 0, 1, 1, 32'h200, '0, 32'hAB);
        checkOutput("full.popblock", 0, 0, 0, 1, 0, '0, 32'hAB);
        applyStimulus(1, 0, 1, 0, 32'h200, '0, '0);
        checkOutput("full.reaccept", 1, 1, 0, 0, 0, 32'h200, '0);

        // Randomized traffic against the reference model.
        doReset();
        q.delete();
        lk = 0; lk_own = 0; last = 1;
        for (int c = 0; c < 500; c++) begin
            inst_sram_req    = ($urandom_range(0, 9) < 6);
            data_sram_req    = ($urandom_range(0, 9) < 5);
            mem_sram_addr_ok = ($urandom_range(0, 1) == 1);
            mem_sram_data_ok = ($urandom_range(0, 9) < 4);
            mem_sram_rdata   = $urandom;
            inst_sram_wr     = 1'($urandom);
            inst_sram_size   = 2'($urandom);
            inst_sram_addr   = $urandom;
            inst_sram_wstrb  = 4'($urandom);
            inst_sram_wdata  = $urandom;
            data_sram_wr     = 1'($urandom);
            data_sram_size   = 2'($urandom);
            data_sram_addr   = $urandom;
            data_sram_wstrb  = 4'($urandom);
            data_sram_wdata  = $urandom;

            g     = modelGrant(inst_sram_req, data_sram_req);
            e_req = (g ? data_sram_req : inst_sram_req) && (q.size() < DEPTH);
            e_acc = e_req && mem_sram_addr_ok;
            e_pop = mem_sram_data_ok && (q.size() > 0);
            hd    = (q.size() > 0) ? q[0] : 1'b0;
            icmd  = {inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata};
            dcmd  = {data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata};

            @(negedge clk);
            checkWord("rnd.mem_req",  71'(mem_sram_req),      71'(e_req));
            checkWord("rnd.inst_aok", 71'(inst_sram_addr_ok), 71'(e_acc && !g));
            checkWord("rnd.data_aok", 71'(data_sram_addr_ok), 71'(e_acc && g));
            checkWord("rnd.inst_dok", 71'(inst_sram_data_ok), 71'(e_pop && !hd));
            checkWord("rnd.data_dok", 71'(data_sram_data_ok), 71'(e_pop && hd));
            if (e_req)
                checkWord("rnd.mem_cmd",
                          {mem_sram_wr, mem_sram_size, mem_sram_addr, mem_sram_wstrb, mem_sram_wdata},
                          g ? dcmd : icmd);
            if (e_pop)
                checkWord("rnd.rdata", 71'(hd ? data_sram_rdata : inst_sram_rdata),
                          71'(mem_sram_rdata));

            @(posedge clk);
            if (e_pop) void'(q.pop_front());
            if (e_acc) begin
                q.push_back(g);
                last = g;
                lk   = 0;
            end else if (e_req) begin
                lk     = 1;
                lk_own = g;
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
